// File: rtl/mem_sram_arb_pkg.sv
// mem_sram_arb_pkg: shared types and default widths for the two-requester
// SRAM arbiter and its tie-break sub-module.
package mem_sram_arb_pkg;

  localparam int unsigned DEF_ADDR_BITS = 8;
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_BURST_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

  function automatic logic [1:0] req_onehot(req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: picks one of the candidate requesters.
// SRAM_ARB_ROUND_ROBIN_EN: when defined, ties go to the requester not served
// most recently; when undefined, requester 0 always wins and no pointer exists.
module sram_arb_pick
  import mem_sram_arb_pkg::*;
(
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_upd,
  input  logic       i_granted,
`endif
  input  logic [1:0] i_cand,
  output logic       o_any,
  output logic       o_sel
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  req_idx_t r_ptr;

  // Pointer holds the preferred requester for the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_upd) begin
      r_ptr <= ~i_granted;
    end
  end

  // Single candidate wins outright; a tie goes to the pointer.
  always_comb begin
    o_any = |i_cand;
    o_sel = (i_cand == 2'b11) ? r_ptr : i_cand[1];
  end
`else
  // Fixed priority: requester 0 whenever it is a candidate.
  always_comb begin
    o_any = |i_cand;
    o_sel = ~i_cand[0];
  end
`endif

endmodule

// File: rtl/mem_sram_arbiter.sv
// mem_sram_arbiter: two-requester arbiter in front of a single-port SRAM with
// 1-cycle registered read data; read responses return two cycles after accept.
// SRAM_ARB_ROUND_ROBIN_EN: round-robin tie-break (default: requester 0 first).
module mem_sram_arbiter
  import mem_sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_we,
  input  logic [1:0][ADDR_BITS-1:0] req_addr,
  input  logic [1:0][DATA_BITS-1:0] req_wdata,
  output logic [1:0]                rsp_valid,
  output logic [DATA_BITS-1:0]      rsp_rdata,
  output logic                      sram_we,
  output logic [ADDR_BITS-1:0]      sram_addr,
  output logic [DATA_BITS-1:0]      sram_wdata,
  input  logic [DATA_BITS-1:0]      sram_rdata
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [3:0]           r_cnt;
  logic                 w_own_vld;
  req_idx_t             w_own;
  logic                 w_hold;
  logic [1:0]           w_cand;
  logic                 w_pick_any;
  req_idx_t             w_pick_sel;
  logic                 w_acc;
  req_idx_t             w_sel;
  logic                 r_p1_vld;
  req_idx_t             r_p1_id;
  logic [1:0]           r_rsp_valid;
  logic [DATA_BITS-1:0] r_rsp_rdata;

  // Ownership: keep the current owner while its burst lasts, otherwise offer
  // the port to the other requester first, and to anyone if it is idle.
  always_comb begin
    w_own_vld = (r_state != IDLE);
    w_own     = (r_state == GNT1);
    w_hold    = w_own_vld && req_valid[w_own] && (r_cnt < BMAX);
`ifndef SRAM_ARB_ROUND_ROBIN_EN
    // Fixed priority: a waiting requester 0 preempts requester 1.
    if (w_own && req_valid[0]) begin
      w_hold = 1'b0;
    end
`endif
    w_cand = req_valid;
    if (w_own_vld && ((req_valid & ~req_onehot(w_own)) != 2'b00)) begin
      w_cand = req_valid & ~req_onehot(w_own);
    end
  end

  sram_arb_pick u_pick (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .i_upd     (w_acc),
    .i_granted (w_sel),
`endif
    .i_cand    (w_cand),
    .o_any     (w_pick_any),
    .o_sel     (w_pick_sel)
  );

  // Accept decision; the same-cycle grant (including from IDLE) avoids dead cycles.
  always_comb begin
    w_acc = rst_n && (w_hold || w_pick_any);
    w_sel = w_hold ? w_own : w_pick_sel;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state follows the requester served this cycle.
  always_comb begin
    w_state_nxt = IDLE;
    if (w_acc) begin
      w_state_nxt = w_sel ? GNT1 : GNT0;
    end
  end

  // Handshake and SRAM command driven straight from the accepted request.
  always_comb begin
    req_ready  = '0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_acc) begin
      req_ready  = req_onehot(w_sel);
      sram_we    = req_we[w_sel];
      sram_addr  = req_addr[w_sel];
      sram_wdata = req_wdata[w_sel];
    end
  end

  // Burst counter: 1 on every new grant, counts accepts while the grant is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_acc) begin
      r_cnt <= '0;
    end else if (w_hold) begin
      r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd1;
    end
  end

  // Read return pipe: stage 1 waits for SRAM data, stage 2 presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld    <= 1'b0;
      r_p1_id     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_p1_vld    <= w_acc && !req_we[w_sel];
      r_p1_id     <= w_sel;
      r_rsp_valid <= r_p1_vld ? req_onehot(r_p1_id) : 2'b00;
      if (r_p1_vld) begin
        r_rsp_rdata <= sram_rdata;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// tb_mem_sram_arbiter: table-driven vectors plus hand sequences, with a
// response scoreboard fed at drive time and drained by a response monitor.
module tb_mem_sram_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [1:0][7:0] req_addr;
  logic [1:0][7:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [7:0]      rsp_rdata;
  logic            sram_we;
  logic [7:0]      sram_addr;
  logic [7:0]      sram_wdata;
  logic [7:0]      sram_rdata;

  typedef struct {
    logic [1:0] v;
    logic [1:0] we;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] rdy;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } sb_t;

  vec_t       tbl [16];
  sb_t        sb [$];
  sb_t        mon_e;
  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  mem_sram_arbiter #(
    .ADDR_BITS (8),
    .DATA_BITS (8),
    .BURST_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM with registered read data (read returns pre-write contents).
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  function automatic logic [1:0] oh(logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk);
    #1;
    req_valid    = v;
    req_we       = we;
    req_addr[0]  = a0;
    req_addr[1]  = a1;
    req_wdata[0] = d0;
    req_wdata[1] = d1;
    @(negedge clk);
  endtask

  // Checks the handshake and SRAM command against the expected grant and
  // updates the reference memory / response scoreboard from the stimulus.
  task automatic expect_accept(input string tag, input logic [1:0] exp_rdy);
    logic       idx;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    sb_t        e;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy == 2'b00) begin
      chk({tag, ".sram_we"}, 32'(sram_we), 32'd0);
    end else begin
      idx = exp_rdy[1];
      w   = req_we[idx];
      a   = req_addr[idx];
      d   = req_wdata[idx];
      chk({tag, ".sram_we"}, 32'(sram_we), 32'(w));
      chk({tag, ".sram_addr"}, 32'(sram_addr), 32'(a));
      if (w) begin
        chk({tag, ".sram_wdata"}, 32'(sram_wdata), 32'(d));
        shadow[a] = d;
      end else begin
        e.id   = idx;
        e.data = shadow[a];
        e.due  = cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  // Response monitor: each expected read must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(oh(mon_e.id)));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
      end else if (rsp_valid != 2'b00) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wt [2];
    int   maxw;
    logic g;

    // v, we, a0, a1, d0, d1, expected ready
    tbl[0]  = '{2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01};
    tbl[1]  = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01};
    tbl[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[3]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[4]  = '{2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h3C, 2'b10};
    tbl[5]  = '{2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10};
    tbl[6]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[7]  = '{2'b01, 2'b01, 8'hFF, 8'h00, 8'h5A, 8'h00, 2'b01};
    tbl[8]  = '{2'b01, 2'b01, 8'h00, 8'h00, 8'hC3, 8'h00, 2'b01};
    tbl[9]  = '{2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b01};
    tbl[10] = '{2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01};
    tbl[11] = '{2'b11, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b10};
    tbl[12] = '{2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 2'b10};
    tbl[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[14] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[15] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};

    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state, with a request pending to show ready stays low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", 32'(req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset.sram_we", 32'(sram_we), 32'd0);
    chk("reset.sram_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    #2;
    rst_n = 1'b1;

    // Single read, write-then-read, address wrap and burst bound.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      expect_accept($sformatf("vec%0d", i), tbl[i].rdy);
    end

    // Contention: both requesters stream reads.
    wt[0] = 0;
    wt[1] = 0;
    maxw  = 0;
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, 2'b00, 8'h10, 8'hFF, 8'h00, 8'h00);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      g = ((k / 4) % 2) == 1;
`else
      g = (k % 5) == 4;
`endif
      expect_accept($sformatf("cont%0d", k), oh(g));
      for (int r = 0; r < 2; r++) begin
        if (req_ready[r]) begin
          wt[r] = 0;
        end else begin
          wt[r]++;
          if (wt[r] > maxw) maxw = wt[r];
        end
      end
    end
    chk("cont.max_wait_le4", 32'(maxw <= 4), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_accept($sformatf("drain%0d", k), 2'b00);
    end

    // Reset one cycle after a read is accepted: the read must vanish.
    drive(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00);
    expect_accept("rst_rd", 2'b01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rstmid.ready", 32'(req_ready), 32'd0);
    chk("rstmid.sram_we", 32'(sram_we), 32'd0);
    chk("rstmid.sram_addr", 32'(sram_addr), 32'd0);
    chk("rstmid.sram_wdata", 32'(sram_wdata), 32'd0);
    chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid.rsp_rdata", 32'(rsp_rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.rsp_valid", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("post_rst%0d.rsp_rdata", k), 32'(rsp_rdata), 32'd0);
    end

    // Recovery: a fresh read after reset returns normally.
    drive(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00);
    expect_accept("recover", 2'b01);
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_accept($sformatf("tail%0d", k), 2'b00);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
